// File: rtl/seg_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Segment codes are active-low, bit0..6 = a..g, bit7 = DP (1 = off).
package seg_pkg;

  localparam int SLOT_CYCLES_DEF = 100000;
  localparam int NUM_DIG         = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Indexed by nibble value; 10..15 are not BCD and render blank.
  localparam logic [15:0][7:0] SEG_CODE = {
    {6{SEG_BLANK}},
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble to active-low segment pattern, DP off.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  assign seg = SEG_CODE[bcd];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit display driver: frame-synchronous digit update,
// per-slot PWM brightness, leading-zero blanking and a toggling colon DP.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] digit_in,
  input  logic        load,
  input  logic [3:0]  brightness,
  input  logic        blank_lz,
  input  logic        sec_tick,
  output logic        upd_pending,
  output logic        frame_start,
  output logic [3:0]  SS_AN,
  output logic [7:0]  SS_CAT
);

  localparam int              CW       = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW:0]     STEP     = (CW+1)'(SLOT_CYCLES / 16);
  localparam logic [CW:0]     ONE      = (CW+1)'(1);

  logic [CW-1:0]              cnt;
  slot_e                      s;
  logic [NUM_DIG-1:0][3:0]    pend, disp;
  logic [NUM_DIG-1:0][7:0]    seg_dig;
  logic                       colon;
  logic [3:0]                 bri_q;

  logic                       wrap, bndry;
  logic [3:0]                 bri;
  logic [CW:0]                thr;
  logic [3:0]                 an_nxt;
  logic [7:0]                 cat_nxt;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
    seg_decode u_dec (.bcd(disp[g]), .seg(seg_dig[g]));
  end

  assign wrap  = (cnt == CNT_LAST);
  assign bndry = wrap && (s == SLOT3);
  // At cnt=0 the live input is the slot's sample; the register holds it afterwards.
  assign bri   = (cnt == '0) ? brightness : bri_q;
  assign thr   = ({{(CW-3){1'b0}}, bri} + ONE) * STEP;

  always_comb begin
    an_nxt  = 4'hF;
    cat_nxt = seg_dig[s];
    if ({1'b0, cnt} < thr) an_nxt[s] = 1'b0;
    if (s == SLOT3 && blank_lz && disp[NUM_DIG-1] == 4'd0)
      cat_nxt = SEG_BLANK;
    else
      cat_nxt[7] = ~(colon && s == SLOT2);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt         <= '0;
      s           <= SLOT0;
      pend        <= '0;
      disp        <= '0;
      colon       <= 1'b0;
      bri_q       <= 4'd0;
      upd_pending <= 1'b0;
      frame_start <= 1'b0;
      SS_AN       <= 4'hF;
      SS_CAT      <= SEG_BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) s <= slot_e'(s + 2'd1);
      if (cnt == '0) bri_q <= brightness;
      if (sec_tick) colon <= ~colon;
      if (load) pend <= digit_in;
      // A load landing on the boundary bypasses pending and commits now.
      if (bndry) begin
        disp        <= load ? digit_in : pend;
        upd_pending <= 1'b0;
      end else if (load) begin
        upd_pending <= 1'b1;
      end
      frame_start <= bndry;
      SS_AN       <= an_nxt;
      SS_CAT      <= cat_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (SLOT_CYCLES=32): directed frames then random
// traffic, checked against a history-based model of the display behaviour.
module tb_seg_scan_driver;

  localparam int SLOT  = 32;
  localparam int FRAME = 4 * SLOT;
  localparam int MAXC  = 8192;

  localparam logic [7:0] REF_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic [15:0] digit_in = '0;
  logic        load = 1'b0;
  logic [3:0]  brightness = '0;
  logic        blank_lz = 1'b0;
  logic        sec_tick = 1'b0;
  logic        upd_pending, frame_start;
  logic [3:0]  SS_AN;
  logic [7:0]  SS_CAT;

  seg_scan_driver #(.SLOT_CYCLES(SLOT)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .digit_in(digit_in),
    .load(load), .brightness(brightness), .blank_lz(blank_lz),
    .sec_tick(sec_tick), .upd_pending(upd_pending), .frame_start(frame_start),
    .SS_AN(SS_AN), .SS_CAT(SS_CAT));

  always #5 CLK100MHZ = ~CLK100MHZ;

  int nchk = 0, nerr = 0;
  int p  = 0;
  int ep = 1;

  logic [15:0] h_dig  [MAXC];
  logic [3:0]  h_bri  [MAXC];
  bit          h_load [MAXC];
  bit          h_tick [MAXC];
  bit          h_blz  [MAXC];

  typedef struct {int ep; int q; int kind; logic [7:0] v;} dchk_t;
  dchk_t dtab[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s ep=%0d p=%0d got=%h exp=%h", tag, ep, p, got, exp);
    end
  endtask

  // Value on display during cycle q: last load at or before the previous frame's end.
  function automatic logic [15:0] disp_at(input int q);
    for (int i = q - (q % FRAME) - 1; i >= 0; i--)
      if (h_load[i]) return h_dig[i];
    return 16'h0;
  endfunction

  function automatic bit upd_at(input int q);
    for (int i = q - 1; i >= 0; i--) begin
      if (i % FRAME == FRAME - 1) return 1'b0;
      if (h_load[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit colon_at(input int q);
    bit c = 1'b0;
    for (int i = 0; i < q; i++) c ^= h_tick[i];
    return c;
  endfunction

  function automatic logic [3:0] exp_an(input int q);
    int s = (q / SLOT) % 4;
    int c = q % SLOT;
    int b = int'(h_bri[q - c]);
    logic [3:0] an = 4'hF;
    if (c < (b + 1) * SLOT / 16) an[s] = 1'b0;
    return an;
  endfunction

  function automatic logic [7:0] exp_cat(input int q);
    int s = (q / SLOT) % 4;
    logic [15:0] d = disp_at(q);
    logic [3:0] dig = d[4*s +: 4];
    logic [7:0] cat;
    if (s == 3 && h_blz[q] && dig == 4'd0) return 8'hFF;
    cat = REF_SEG[dig];
    cat[7] = !(colon_at(q) && s == 2);
    return cat;
  endfunction

  task automatic add(input int e, input int q, input int k, input logic [7:0] v);
    dchk_t d;
    d.ep = e; d.q = q; d.kind = k; d.v = v;
    dtab.push_back(d);
  endtask

  task automatic tick();
    h_dig[p] = digit_in; h_load[p] = load; h_bri[p] = brightness;
    h_tick[p] = sec_tick; h_blz[p] = blank_lz;
    @(posedge CLK100MHZ); #1;
    chk("an", 16'(SS_AN), 16'(exp_an(p)));
    chk("cat", 16'(SS_CAT), 16'(exp_cat(p)));
    p++;
    chk("upd", 16'(upd_pending), 16'(upd_at(p)));
    chk("frame_start", 16'(frame_start), 16'(p > 0 && p % FRAME == 0));
    foreach (dtab[i])
      if (dtab[i].ep == ep && dtab[i].q == p - 1)
        case (dtab[i].kind)
          0: chk("dir_cat", 16'(SS_CAT), 16'(dtab[i].v));
          1: chk("dir_an", 16'(SS_AN), 16'(dtab[i].v));
          2: chk("dir_fs", 16'(frame_start), 16'(dtab[i].v));
          default: chk("dir_upd", 16'(upd_pending), 16'(dtab[i].v));
        endcase
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 16'(SS_AN), 16'h000F);
    chk({tag, "_cat"}, 16'(SS_CAT), 16'h00FF);
    chk({tag, "_upd"}, 16'(upd_pending), 16'h0);
    chk({tag, "_fs"}, 16'(frame_start), 16'h0);
  endtask

  initial begin
    // Spec example expectations, positions are cycle index within the epoch.
    add(1, 1, 1, 8'hE);   add(1, 2, 1, 8'hF);
    add(1, 126, 2, 8'h0); add(1, 127, 2, 8'h1);
    add(1, 39, 3, 8'h0);  add(1, 40, 3, 8'h1);  add(1, 127, 3, 8'h0);
    add(1, 128+5, 0, 8'h99); add(1, 160+5, 0, 8'hB0);
    add(1, 192+5, 0, 8'hA4); add(1, 224+5, 0, 8'hF9);
    add(1, 159, 1, 8'hE);
    add(1, 256+5, 0, 8'hA4);
    add(1, 276, 1, 8'hF);  add(1, 298, 1, 8'hD);
    add(1, 384+5, 0, 8'h80);
    add(1, 512+5, 0, 8'hC0); add(1, 512+96+5, 0, 8'hFF);
    add(1, 640+96+5, 0, 8'hC0);
    add(1, 768+32+5, 0, 8'hB0); add(1, 768+64+5, 0, 8'h10);
    add(1, 896+64+5, 0, 8'h90);
    add(2, 0, 0, 8'hC0); add(2, 128+5, 0, 8'hC0);

    // Reset held with activity on load and sec_tick.
    load = 1'b1; digit_in = 16'h5555; sec_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK100MHZ); #1;
      sec_tick = ~sec_tick;
      chk_reset("rst");
    end
    CPU_RESETN = 1'b1;
    load = 1'b0; sec_tick = 1'b0; digit_in = '0;

    for (int i = 0; i < 1024; i++) begin
      load = 1'b0; sec_tick = 1'b0;
      brightness = (i < 128) ? 4'd0 : (i < 256) ? 4'd15 : (i < 266) ? 4'd3 : 4'd7;
      blank_lz = (i >= 512 && i < 640);
      case (i)
        40:  begin load = 1'b1; digit_in = 16'h1234; end
        150: begin load = 1'b1; digit_in = 16'h1111; end
        200: begin load = 1'b1; digit_in = 16'h2222; end
        383: begin load = 1'b1; digit_in = 16'h5678; end
        420: begin load = 1'b1; digit_in = 16'h0930; end
        770, 900: sec_tick = 1'b1;
        default: ;
      endcase
      tick();
    end

    for (int i = 1024; i < 3072; i++) begin
      load = 1'b0; sec_tick = 1'b0;
      if ($urandom_range(0, 39) == 0 || (i % FRAME == FRAME - 1 && $urandom_range(0, 1) == 0)) begin
        load = 1'b1; digit_in = 16'($urandom);
      end
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
      if (i % FRAME == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 99) == 0) sec_tick = 1'b1;
      tick();
    end

    // Leave a load pending, then reset mid-frame.
    load = 1'b1; digit_in = 16'h4321; sec_tick = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    CPU_RESETN = 1'b0;
    #1 chk_reset("rst_mid");
    load = 1'b1; sec_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK100MHZ); #1;
      chk_reset("rst_hold");
    end
    CPU_RESETN = 1'b1;
    load = 1'b0; sec_tick = 1'b0; blank_lz = 1'b0;
    p = 0; ep = 2;

    for (int i = 0; i < 320; i++) begin
      load = 1'b0; sec_tick = 1'b0;
      if (i >= 200 && $urandom_range(0, 19) == 0) begin
        load = 1'b1; digit_in = 16'($urandom);
      end
      if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
      if (i >= 150 && $urandom_range(0, 49) == 0) sec_tick = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
